issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 138 +++++++++++++
 tb/tb_issue_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Register-write scoreboard for an in-order issue stage. Tracks
//               destination registers of long-latency instructions (LSU/MDU/
//               CSR) whose results return through writeback. It holds any
//               decoded instruction that reads or writes a pending register,
//               and holds new long-latency instructions while MAX_OUT of them
//               are outstanding.
//
// Optional feature macro: SCB_FWD_EN
//   defined   : a writeback clears the hazard on its register in the same
//               cycle, so a dependent instruction issues alongside it.
//   undefined : the dependent instruction issues the cycle after writeback.
//
// Ports:
//   s_clk_i          clock, rising edge
//   s_resetn_i       synchronous active-low reset
//   s_valid_i        decoded instruction present
//   s_ready_i        execute stage accepts this cycle
//   s_rs1_i/s_rs2_i  source register addresses
//   s_rd_i           destination register address
//   s_rp1_i/s_rp2_i  read port 1/2 used
//   s_wdest_i        instruction writes rd
//   s_long_i         result returns via writeback
//   s_wb_valid_i     writeback of a tracked write
//   s_wb_rd_i        writeback register address
//   s_flush_i        kill all tracked in-flight instructions
//   s_issue_o        instruction issued this cycle
//   s_stall_o        instruction held this cycle
//   s_full_o         MAX_OUT writes outstanding
//   s_pending_o      registered pending bitmap (bit 0 always 0)
//   s_err_o          writeback protocol error, one cycle after the bad wb
//
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int MAX_OUT = 4
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_valid_i,
    input  logic        s_ready_i,
    input  logic [4:0]  s_rs1_i,
    input  logic [4:0]  s_rs2_i,
    input  logic [4:0]  s_rd_i,
    input  logic        s_rp1_i,
    input  logic        s_rp2_i,
    input  logic        s_wdest_i,
    input  logic        s_long_i,
    input  logic        s_wb_valid_i,
    input  logic [4:0]  s_wb_rd_i,
    input  logic        s_flush_i,
    output logic        s_issue_o,
    output logic        s_stall_o,
    output logic        s_full_o,
    output logic [31:0] s_pending_o,
    output logic        s_err_o
);

    localparam int                 c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUT);

    logic [31:0]        pending_q, pending_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;

    logic [31:0] w_pend_eff;
    logic        w_tracked;
    logic        w_hazard;
    logic        w_block;
    logic        w_trk_issue;
    logic        w_wb_ok;

    // Writes to x0 are never tracked, so bit 0 of the bitmap stays clear.
    assign w_tracked = s_wdest_i & s_long_i & (s_rd_i != 5'd0);

`ifdef SCB_FWD_EN
    // A writeback arriving this cycle already resolves its register.
    assign w_pend_eff = s_wb_valid_i ? (pending_q & ~(32'd1 << s_wb_rd_i)) : pending_q;
`else
    assign w_pend_eff = pending_q;
`endif

    assign w_hazard = (s_rp1_i   & (s_rs1_i != 5'd0) & w_pend_eff[s_rs1_i])
                    | (s_rp2_i   & (s_rs2_i != 5'd0) & w_pend_eff[s_rs2_i])
                    | (s_wdest_i & (s_rd_i  != 5'd0) & w_pend_eff[s_rd_i]);

    assign w_block     = (w_tracked & s_full_o) | w_hazard | s_flush_i;
    assign s_issue_o   = s_resetn_i & s_valid_i & s_ready_i & ~w_block;
    assign s_stall_o   = s_valid_i & w_block;
    assign w_trk_issue = s_issue_o & w_tracked;

    // A writeback is legitimate only for a register we are actually tracking.
    assign w_wb_ok = s_wb_valid_i & pending_q[s_wb_rd_i] & (count_q != '0);

    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = 1'b0;
        if (s_flush_i) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            err_d = s_wb_valid_i & ~w_wb_ok;
            // Clear before set so that a same-register issue wins.
            if (w_wb_ok) begin
                pending_d[s_wb_rd_i] = 1'b0;
            end
            if (w_trk_issue) begin
                pending_d[s_rd_i] = 1'b1;
            end
            case ({w_trk_issue, w_wb_ok})
                2'b10:   count_d = (count_q == c_MAX) ? count_q : count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign s_full_o    = (count_q == c_MAX);
    assign s_pending_o = pending_q;
    assign s_err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Directed self-checking bench for issue_scoreboard (MAX_OUT=4).
//               Expected values are hand-derived; SCB_FWD_EN selects the
//               forwarding-dependent expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

    logic        s_clk_i = 1'b0;
    logic        s_resetn_i;
    logic        s_valid_i, s_ready_i;
    logic [4:0]  s_rs1_i, s_rs2_i, s_rd_i;
    logic        s_rp1_i, s_rp2_i, s_wdest_i, s_long_i;
    logic        s_wb_valid_i;
    logic [4:0]  s_wb_rd_i;
    logic        s_flush_i;
    logic        s_issue_o, s_stall_o, s_full_o, s_err_o;
    logic [31:0] s_pending_o;

    int n_checks = 0;
    int n_fail   = 0;

    issue_scoreboard #(.MAX_OUT(4)) u_dut (
        .s_clk_i      (s_clk_i),
        .s_resetn_i   (s_resetn_i),
        .s_valid_i    (s_valid_i),
        .s_ready_i    (s_ready_i),
        .s_rs1_i      (s_rs1_i),
        .s_rs2_i      (s_rs2_i),
        .s_rd_i       (s_rd_i),
        .s_rp1_i      (s_rp1_i),
        .s_rp2_i      (s_rp2_i),
        .s_wdest_i    (s_wdest_i),
        .s_long_i     (s_long_i),
        .s_wb_valid_i (s_wb_valid_i),
        .s_wb_rd_i    (s_wb_rd_i),
        .s_flush_i    (s_flush_i),
        .s_issue_o    (s_issue_o),
        .s_stall_o    (s_stall_o),
        .s_full_o     (s_full_o),
        .s_pending_o  (s_pending_o),
        .s_err_o      (s_err_o)
    );

    always #5 s_clk_i = ~s_clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge s_clk_i);
        #1;
    endtask

    task automatic instr(input logic v, input logic r,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rp1, input logic rp2, input logic wd, input logic lg);
        s_valid_i = v;   s_ready_i = r;
        s_rs1_i   = rs1; s_rs2_i   = rs2; s_rd_i = rd;
        s_rp1_i   = rp1; s_rp2_i   = rp2;
        s_wdest_i = wd;  s_long_i  = lg;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        s_wb_valid_i = v;
        s_wb_rd_i    = rd;
    endtask

    task automatic idle();
        instr(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        wb(1'b0, 5'd0);
        s_flush_i = 1'b0;
    endtask

    // Issue one tracked instruction (no sources) and advance a cycle.
    task automatic issue_tracked(input logic [4:0] rd, input string tag);
        instr(1'b1, 1'b1, 5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check_val(tag, {31'd0, s_issue_o}, 32'd1);
        tick();
        idle();
    endtask

    task automatic do_flush();
        idle();
        s_flush_i = 1'b1;
        tick();
        s_flush_i = 1'b0;
    endtask

    initial begin
        idle();
        s_resetn_i = 1'b0;

        // ---------------- reset ----------------
        tick();
        instr(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_val("issue_in_reset", {31'd0, s_issue_o}, 32'd0);
        tick();
        idle();
        s_resetn_i = 1'b1;
        #1;
        check_val("rst_pending", s_pending_o, 32'd0);
        check_val("rst_full",    {31'd0, s_full_o}, 32'd0);
        check_val("rst_err",     {31'd0, s_err_o},  32'd0);
        tick();

        // ---------------- load-use dependency ----------------
        instr(1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);   // cycle 0
        #1;
        check_val("lu_load_issue", {31'd0, s_issue_o}, 32'd1);
        tick();
        instr(1'b1, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);   // cycle 1
        #1;
        check_val("lu_pending5", s_pending_o, 32'h0000_0020);
        check_val("lu_stall_c1", {31'd0, s_stall_o}, 32'd1);
        check_val("lu_issue_c1", {31'd0, s_issue_o}, 32'd0);
        tick();                                                       // cycle 2
        check_val("lu_stall_c2", {31'd0, s_stall_o}, 32'd1);
        tick();
        wb(1'b1, 5'd5);                                               // cycle 3
        #1;
`ifdef SCB_FWD_EN
        check_val("lu_issue_c3", {31'd0, s_issue_o}, 32'd1);
        check_val("lu_stall_c3", {31'd0, s_stall_o}, 32'd0);
`else
        check_val("lu_issue_c3", {31'd0, s_issue_o}, 32'd0);
        check_val("lu_stall_c3", {31'd0, s_stall_o}, 32'd1);
`endif
        tick();
        wb(1'b0, 5'd0);                                               // cycle 4
`ifdef SCB_FWD_EN
        s_valid_i = 1'b0;
`endif
        #1;
        check_val("lu_pending_clr", s_pending_o, 32'd0);
`ifndef SCB_FWD_EN
        check_val("lu_issue_c4", {31'd0, s_issue_o}, 32'd1);
`endif
        check_val("lu_err", {31'd0, s_err_o}, 32'd0);
        tick();
        idle();

        // ---------------- fill to MAX_OUT ----------------
        for (int i = 1; i <= 4; i++) issue_tracked(5'(i), "full_issue");
        instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);   // cycle 4
        #1;
        check_val("full_flag",     {31'd0, s_full_o},  32'd1);
        check_val("full_pending",  s_pending_o,        32'h0000_001E);
        check_val("full_stall_c4", {31'd0, s_stall_o}, 32'd1);
        check_val("full_issue_c4", {31'd0, s_issue_o}, 32'd0);
        tick();                                                       // cycle 5
        check_val("full_stall_c5", {31'd0, s_stall_o}, 32'd1);
        tick();
        wb(1'b1, 5'd1);                                               // cycle 6
        #1;
        check_val("full_stall_c6", {31'd0, s_stall_o}, 32'd1);
        tick();
        wb(1'b0, 5'd0);                                               // cycle 7
        #1;
        check_val("full_drop",     {31'd0, s_full_o},  32'd0);
        check_val("full_issue_c7", {31'd0, s_issue_o}, 32'd1);
        check_val("full_pend_c7",  s_pending_o,        32'h0000_001C);
        tick();
        idle();
        #1;
        check_val("full_pend_c8",  s_pending_o,        32'h0000_003C);
        check_val("full_again",    {31'd0, s_full_o},  32'd1);
        do_flush();
        #1;
        check_val("flush_clean_pend", s_pending_o,       32'd0);
        check_val("flush_clean_full", {31'd0, s_full_o}, 32'd0);

        // ---------------- same-register issue and writeback ----------------
        issue_tracked(5'd7, "same_first");
        instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        wb(1'b1, 5'd7);
        #1;
`ifdef SCB_FWD_EN
        check_val("same_issue", {31'd0, s_issue_o}, 32'd1);
`else
        check_val("same_stall", {31'd0, s_stall_o}, 32'd1);
`endif
        tick();
        idle();
        #1;
`ifdef SCB_FWD_EN
        check_val("same_pend7", s_pending_o, 32'h0000_0080);
`else
        check_val("same_pend7", s_pending_o, 32'd0);
`endif
        issue_tracked(5'd8,  "same_fill");
        issue_tracked(5'd9,  "same_fill");
        issue_tracked(5'd10, "same_fill");
        #1;
`ifdef SCB_FWD_EN
        check_val("same_count_full", {31'd0, s_full_o}, 32'd1);
`else
        check_val("same_count_full", {31'd0, s_full_o}, 32'd0);
`endif
        do_flush();

        // ---------------- flush overriding issue and writeback ----------------
        issue_tracked(5'd2, "fl_issue");
        issue_tracked(5'd3, "fl_issue");
        issue_tracked(5'd4, "fl_issue");
        #1;
        check_val("fl_pend_before", s_pending_o, 32'h0000_001C);
        instr(1'b1, 1'b1, 5'd1, 5'd0, 5'd20, 1'b1, 1'b0, 1'b1, 1'b0);
        wb(1'b1, 5'd2);
        s_flush_i = 1'b1;
        #1;
        check_val("fl_no_issue", {31'd0, s_issue_o}, 32'd0);
        check_val("fl_stall",    {31'd0, s_stall_o}, 32'd1);
        tick();
        idle();
        #1;
        check_val("fl_pend_after", s_pending_o,        32'd0);
        check_val("fl_full_after", {31'd0, s_full_o},  32'd0);
        check_val("fl_no_err",     {31'd0, s_err_o},   32'd0);
        wb(1'b1, 5'd2);
        tick();
        idle();
        #1;
        check_val("fl_stale_wb_err", {31'd0, s_err_o}, 32'd1);
        tick();
        check_val("fl_err_clears",   {31'd0, s_err_o}, 32'd0);

        // ---------------- spurious writeback, x0 operands ----------------
        wb(1'b1, 5'd9);
        tick();
        idle();
        #1;
        check_val("spur_err",  {31'd0, s_err_o}, 32'd1);
        check_val("spur_pend", s_pending_o,      32'd0);
        tick();
        check_val("spur_err_once", {31'd0, s_err_o}, 32'd0);
        issue_tracked(5'd3, "x0_setup");
        instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check_val("x0_issue", {31'd0, s_issue_o}, 32'd1);
        check_val("x0_stall", {31'd0, s_stall_o}, 32'd0);
        tick();
        instr(1'b1, 1'b1, 5'd1, 5'd3, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check_val("rs2_hazard", {31'd0, s_stall_o}, 32'd1);
        instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_val("notready_issue", {31'd0, s_issue_o}, 32'd0);
        check_val("notready_stall", {31'd0, s_stall_o}, 32'd0);
        idle();
        #1;
        check_val("x0_untracked", s_pending_o, 32'h0000_0008);

        // ---------------- reset with outstanding writes ----------------
        issue_tracked(5'd11, "rst2_issue");
        #1;
        check_val("rst2_pend_before", s_pending_o, 32'h0000_0808);
        s_resetn_i = 1'b0;
        tick();
        s_resetn_i = 1'b1;
        #1;
        check_val("rst2_pend", s_pending_o,       32'd0);
        check_val("rst2_full", {31'd0, s_full_o}, 32'd0);
        wb(1'b1, 5'd11);
        tick();
        idle();
        #1;
        check_val("rst2_err_wb11", {31'd0, s_err_o}, 32'd1);
        tick();
        check_val("rst2_err_gap", {31'd0, s_err_o}, 32'd0);
        wb(1'b1, 5'd3);
        tick();
        idle();
        #1;
        check_val("rst2_err_wb3", {31'd0, s_err_o}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
